// File: rtl/timer_interrupt_ctrl.sv
// Memory-mapped programmable timer on the core's data bus.
// A prescaler divides the clock into ticks; each tick advances COUNT,
// and a COUNT==COMPARE match latches PENDING. The core's interrupt input
// is driven by a one-cycle pulse on each rising edge of PENDING & IE.
module timer_interrupt_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_waddr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic [31:0] bus_raddr,
    output logic [31:0] bus_rdata,
    output logic        bus_hit,
    output logic        irq_out
);

    // Word offsets inside the register window
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    logic [2:0]            ctrl_r;
    logic [PRESCALE_W-1:0] prescale_r;
    logic [PRESCALE_W-1:0] pscnt_r;
    logic [31:0]           count_r;
    logic [31:0]           compare_r;
    logic                  pending_r;
    logic                  irq_lvl_r;
    logic                  irq_out_r;

    // Word offset relative to the base; an address below the base wraps to
    // a large value and therefore falls outside the window.
    logic [29:0] woff_s;
    logic [29:0] roff_s;
    logic        wr_ctrl_s;
    logic        wr_prescale_s;
    logic        wr_count_s;
    logic        wr_compare_s;
    logic        wr_status_s;
    logic        tick_s;
    logic        match_s;
    logic        irq_lvl_next_s;

    assign woff_s         = bus_waddr[31:2] - BASE_ADDR[31:2];
    assign roff_s         = bus_raddr[31:2] - BASE_ADDR[31:2];
    assign tick_s         = ctrl_r[0] && (pscnt_r == prescale_r);
    // Match is judged on the COUNT value held before any same-cycle write
    assign match_s        = tick_s && (count_r == compare_r);
    assign irq_lvl_next_s = pending_r & ctrl_r[1];
    assign irq_out        = irq_out_r;

    // Write-strobe decode; the byte-offset bits of the write address are ignored
    always_comb begin
        wr_ctrl_s     = 1'b0;
        wr_prescale_s = 1'b0;
        wr_count_s    = 1'b0;
        wr_compare_s  = 1'b0;
        wr_status_s   = 1'b0;
        if (bus_we && (woff_s < 30'd5)) begin
            case (woff_s[2:0])
                OFF_CTRL:     wr_ctrl_s     = 1'b1;
                OFF_PRESCALE: wr_prescale_s = 1'b1;
                OFF_COUNT:    wr_count_s    = 1'b1;
                OFF_COMPARE:  wr_compare_s  = 1'b1;
                OFF_STATUS:   wr_status_s   = 1'b1;
                default:      wr_ctrl_s     = 1'b0;
            endcase
        end else begin
            wr_ctrl_s = 1'b0;
        end
    end

    // Combinational read mux; only word-aligned addresses in the window hit
    always_comb begin
        bus_hit   = 1'b0;
        bus_rdata = 32'd0;
        if ((bus_raddr[1:0] == 2'b00) && (roff_s < 30'd5)) begin
            bus_hit = 1'b1;
            case (roff_s[2:0])
                OFF_CTRL:     bus_rdata[2:0]            = ctrl_r;
                OFF_PRESCALE: bus_rdata[PRESCALE_W-1:0] = prescale_r;
                OFF_COUNT:    bus_rdata                 = count_r;
                OFF_COMPARE:  bus_rdata                 = compare_r;
                OFF_STATUS:   bus_rdata[0]              = pending_r;
                default:      bus_rdata                 = 32'd0;
            endcase
        end else begin
            bus_hit   = 1'b0;
            bus_rdata = 32'd0;
        end
    end

    // Software-owned configuration registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_r     <= 3'd0;
            prescale_r <= {PRESCALE_W{1'b0}};
            compare_r  <= 32'hFFFF_FFFF;
        end else begin
            if (wr_ctrl_s)     ctrl_r     <= bus_wdata[2:0];
            if (wr_prescale_s) prescale_r <= bus_wdata[PRESCALE_W-1:0];
            if (wr_compare_s)  compare_r  <= bus_wdata;
        end
    end

    // Prescaler: a reload write restarts it, disabled timer holds it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pscnt_r <= {PRESCALE_W{1'b0}};
        end else if (wr_prescale_s) begin
            pscnt_r <= {PRESCALE_W{1'b0}};
        end else if (tick_s) begin
            pscnt_r <= {PRESCALE_W{1'b0}};
        end else if (ctrl_r[0]) begin
            pscnt_r <= pscnt_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end

    // COUNT: software write wins over tick increment and auto-reload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 32'd0;
        end else if (wr_count_s) begin
            count_r <= bus_wdata;
        end else if (match_s && ctrl_r[2]) begin
            count_r <= 32'd0;
        end else if (tick_s) begin
            count_r <= count_r + 32'd1;
        end
    end

    // PENDING: hardware set wins over a same-cycle write-one-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= 1'b0;
        end else if (match_s) begin
            pending_r <= 1'b1;
        end else if (wr_status_s && bus_wdata[0]) begin
            pending_r <= 1'b0;
        end
    end

    // Registered interrupt level and its rising-edge pulse to the core
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_lvl_r <= 1'b0;
            irq_out_r <= 1'b0;
        end else begin
            irq_lvl_r <= irq_lvl_next_s;
            irq_out_r <= irq_lvl_next_s & ~irq_lvl_r;
        end
    end

endmodule

// File: tb/tb_timer_interrupt_ctrl.sv
// Directed testbench for timer_interrupt_ctrl: a table of register/decode
// vectors followed by hand-timed sequences for counting, interrupts and
// same-cycle collisions.
module tb_timer_interrupt_ctrl;

    localparam logic [31:0] BASE = 32'h0000_FF00;

    logic        clk;
    logic        reset;
    logic [31:0] bus_waddr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [31:0] bus_raddr;
    logic [31:0] bus_rdata;
    logic        bus_hit;
    logic        irq_out;

    int checks;
    int failures;

    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic        exp_hit;
    } vec_t;

    vec_t vecs[16];

    timer_interrupt_ctrl #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_waddr (bus_waddr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_raddr (bus_raddr),
        .bus_rdata (bus_rdata),
        .bus_hit   (bus_hit),
        .irq_out   (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic rd(input string nm, input logic [31:0] off, input logic [31:0] exp);
        bus_raddr = BASE + off;
        #1;
        chk(nm, bus_rdata, exp);
    endtask

    // Write lands on the next rising edge; returns 1 time unit after it
    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        @(negedge clk);
        bus_waddr = BASE + off;
        bus_wdata = d;
        bus_we    = 1'b1;
        @(posedge clk);
        #1;
        bus_we = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset  = 1'b0;
        bus_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        bus_we    = 1'b0;
        bus_waddr = 32'd0;
        bus_wdata = 32'd0;
        bus_raddr = BASE;

        // reads/writes with the timer disabled
        vecs[0]  = '{1'b0, 32'd0,        32'd0,         BASE,          32'd0,         1'b1};
        vecs[1]  = '{1'b0, 32'd0,        32'd0,         BASE + 32'h04, 32'd0,         1'b1};
        vecs[2]  = '{1'b0, 32'd0,        32'd0,         BASE + 32'h08, 32'd0,         1'b1};
        vecs[3]  = '{1'b0, 32'd0,        32'd0,         BASE + 32'h0C, 32'hFFFF_FFFF, 1'b1};
        vecs[4]  = '{1'b0, 32'd0,        32'd0,         BASE + 32'h10, 32'd0,         1'b1};
        vecs[5]  = '{1'b0, 32'd0,        32'd0,         BASE + 32'h14, 32'd0,         1'b0};
        vecs[6]  = '{1'b0, 32'd0,        32'd0,         BASE - 32'h04, 32'd0,         1'b0};
        vecs[7]  = '{1'b0, 32'd0,        32'd0,         BASE + 32'h02, 32'd0,         1'b0};
        vecs[8]  = '{1'b1, BASE,         32'hFFFF_FFFA, BASE,          32'd2,         1'b1};
        vecs[9]  = '{1'b1, BASE+32'h04,  32'hABCD_1234, BASE + 32'h04, 32'h0000_1234, 1'b1};
        vecs[10] = '{1'b1, BASE+32'h08,  32'hDEAD_BEEF, BASE + 32'h08, 32'hDEAD_BEEF, 1'b1};
        vecs[11] = '{1'b1, BASE+32'h0C,  32'h1234_5678, BASE + 32'h0C, 32'h1234_5678, 1'b1};
        vecs[12] = '{1'b1, BASE+32'h14,  32'h0000_0000, BASE + 32'h08, 32'hDEAD_BEEF, 1'b1};
        vecs[13] = '{1'b1, BASE+32'h0B,  32'h0000_0007, BASE + 32'h08, 32'h0000_0007, 1'b1};
        vecs[14] = '{1'b1, BASE-32'h04,  32'h0000_0000, BASE + 32'h0C, 32'h1234_5678, 1'b1};
        vecs[15] = '{1'b1, BASE+32'h10,  32'h0000_0001, BASE + 32'h10, 32'd0,         1'b1};

        repeat (2) @(negedge clk);
        reset = 1'b1;

        // ---- reset in the middle of a counting run with irq_out high ----
        wr(32'h04, 32'd0);
        wr(32'h0C, 32'd2);
        wr(32'h00, 32'd3);
        repeat (4) step();
        chk("pre_reset_irq", {31'd0, irq_out}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_reset_irq", {31'd0, irq_out}, 32'd0);
        rd("async_reset_count", 32'h08, 32'd0);
        rd("async_reset_status", 32'h10, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_reset_irq", {31'd0, irq_out}, 32'd0);
        end

        // ---- table: reset values, register access, decode ----
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus_we    = vecs[i].we;
            bus_waddr = vecs[i].waddr;
            bus_wdata = vecs[i].wdata;
            bus_raddr = vecs[i].raddr;
            @(posedge clk);
            #1;
            bus_we = 1'b0;
            chk($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_hit", i), {31'd0, bus_hit}, {31'd0, vecs[i].exp_hit});
            chk($sformatf("vec%0d_irq", i), {31'd0, irq_out}, 32'd0);
        end

        // ---- basic match: PRESCALE=0, COMPARE=5, EN|IE ----
        do_reset();
        wr(32'h04, 32'd0);
        wr(32'h0C, 32'd5);
        wr(32'h00, 32'd3);
        repeat (5) step();
        rd("basic_count5", 32'h08, 32'd5);
        rd("basic_pend0", 32'h10, 32'd0);
        step();
        rd("basic_count6", 32'h08, 32'd6);
        rd("basic_pend1", 32'h10, 32'd1);
        chk("basic_irq_before", {31'd0, irq_out}, 32'd0);
        step();
        chk("basic_irq_pulse", {31'd0, irq_out}, 32'd1);
        step();
        chk("basic_irq_after", {31'd0, irq_out}, 32'd0);
        step();
        chk("basic_irq_quiet", {31'd0, irq_out}, 32'd0);

        // ---- prescaler and auto-reload: PRESCALE=3, COMPARE=2, all on ----
        do_reset();
        wr(32'h04, 32'd3);
        wr(32'h0C, 32'd2);
        wr(32'h00, 32'd7);
        for (int i = 1; i <= 24; i++) begin
            if (i == 14) begin
                bus_waddr = BASE + 32'h10;
                bus_wdata = 32'd1;
                bus_we    = 1'b1;
            end
            @(posedge clk);
            #1;
            bus_we = 1'b0;
            rd($sformatf("ar_count_c%0d", i), 32'h08, (i / 4) % 3);
            rd($sformatf("ar_pend_c%0d", i), 32'h10,
               ((i >= 12 && i < 14) || i >= 24) ? 32'd1 : 32'd0);
        end

        // ---- interrupt gating: match with IE=0, then enable, then clear ----
        do_reset();
        wr(32'h04, 32'd0);
        wr(32'h0C, 32'd0);
        wr(32'h00, 32'd1);
        step();
        rd("gate_pend", 32'h10, 32'd1);
        rd("gate_pend_reread", 32'h10, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("gate_irq_masked", {31'd0, irq_out}, 32'd0);
        end
        wr(32'h00, 32'd3);
        chk("gate_irq_pre", {31'd0, irq_out}, 32'd0);
        step();
        chk("gate_irq_pulse", {31'd0, irq_out}, 32'd1);
        step();
        chk("gate_irq_end", {31'd0, irq_out}, 32'd0);
        wr(32'h10, 32'd0);
        rd("gate_w0_noeffect", 32'h10, 32'd1);
        wr(32'h10, 32'd1);
        rd("gate_w1c", 32'h10, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("gate_irq_cleared", {31'd0, irq_out}, 32'd0);
        end

        // ---- collisions ----
        do_reset();
        wr(32'h04, 32'd0);
        wr(32'h0C, 32'd3);
        wr(32'h00, 32'd1);
        repeat (3) step();
        rd("col_count3", 32'h08, 32'd3);
        bus_waddr = BASE + 32'h10;
        bus_wdata = 32'd1;
        bus_we    = 1'b1;
        step();
        bus_we = 1'b0;
        rd("col_set_beats_w1c", 32'h10, 32'd1);
        rd("col_count4", 32'h08, 32'd4);
        wr(32'h08, 32'h100);
        rd("col_count_write", 32'h08, 32'h100);
        step();
        rd("col_count_inc", 32'h08, 32'h101);
        // COUNT write on a matching tick: match judged on old COUNT
        wr(32'h00, 32'd0);
        wr(32'h10, 32'd1);
        wr(32'h08, 32'h20);
        wr(32'h0C, 32'h20);
        rd("col_pend_cleared", 32'h10, 32'd0);
        wr(32'h00, 32'd1);
        bus_waddr = BASE + 32'h08;
        bus_wdata = 32'h55;
        bus_we    = 1'b1;
        step();
        bus_we = 1'b0;
        rd("col_prewrite_match", 32'h10, 32'd1);
        rd("col_write_wins", 32'h08, 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
